// File: rtl/rst_seq_gen.sv
// Staggered multi-channel active-low reset release plus per-channel divided clock enables.
// Defining RST_SEQ_WDOG_EN adds a watchdog that forces a soft-reset replay on timeout.
module rst_seq_gen #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8,
    parameter int RST_LEN0 = 2,
    parameter int RST_STEP = 8,
    parameter int CE_DIV0  = 2,
    parameter int WDOG_LEN = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_req,
    output logic              soft_ack,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic [NUM_CH-1:0] ch_ce,
    output logic              seq_done
`ifdef RST_SEQ_WDOG_EN
    ,
    input  logic              wdog_kick,
    output logic              wdog_fired
`endif
);

    localparam int L_LAST = RST_LEN0 + (NUM_CH - 1) * RST_STEP;
    localparam int P_MAX  = CE_DIV0 << (NUM_CH - 1);
    localparam int DIV_W  = ($clog2(P_MAX) > 0) ? $clog2(P_MAX) : 1;

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_err_num_ch
        $error("rst_seq_gen: NUM_CH must be 1..16");
    end
    if (RST_LEN0 < 1 || RST_STEP < 0 || CE_DIV0 < 1 || WDOG_LEN < 1) begin : g_err_range
        $error("rst_seq_gen: RST_LEN0, CE_DIV0, WDOG_LEN must be >= 1 and RST_STEP >= 0");
    end
    if (L_LAST > (2 ** CNT_W) - 1) begin : g_err_cnt_w
        $error("rst_seq_gen: CNT_W too narrow for the longest release time");
    end

    typedef enum logic [1:0] {HOLD, RUN, SOFT} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [NUM_CH-1:0] ch_rst_n_q;
    logic [NUM_CH-1:0] ch_rst_n_d;
    logic [NUM_CH-1:0] ch_ce_q;
    logic [NUM_CH-1:0] div_wrap;
    logic [DIV_W-1:0]  div_q [NUM_CH];
    logic [DIV_W-1:0]  div_d [NUM_CH];
    logic              seq_done_q;
    logic              soft_ack_q;
    logic              last_rel;
    logic              go_soft;

    // Channel i releases on the edge where the edge count reaches L_i, i.e. cnt_q == L_i-1.
    always_comb begin
        cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        last_rel = int'(cnt_q) >= L_LAST - 1;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_rst_n_d[i] = ch_rst_n_q[i] | (int'(cnt_q) >= RST_LEN0 + i * RST_STEP - 1);
            div_wrap[i]   = int'(div_q[i]) == (CE_DIV0 << i) - 1;
            div_d[i]      = div_wrap[i] ? '0 : div_q[i] + 1'b1;
        end
    end

`ifdef RST_SEQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_LEN + 1);

    logic [WD_W-1:0] wd_q;
    logic            wd_fire;
    logic            wdog_fired_q;

    // A kick on the timeout cycle suppresses the fire.
    assign wd_fire = (state_q == RUN) && (wd_q == WD_W'(WDOG_LEN - 1)) && !wdog_kick;
    assign go_soft = (state_q == RUN) && (soft_req || wd_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q         <= '0;
            wdog_fired_q <= 1'b0;
        end else begin
            wdog_fired_q <= wd_fire;
            if (state_q != RUN || wdog_kick || go_soft) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + 1'b1;
            end
        end
    end

    assign wdog_fired = wdog_fired_q;
`else
    assign go_soft = (state_q == RUN) && soft_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            ch_rst_n_q <= '0;
            ch_ce_q    <= '0;
            seq_done_q <= 1'b0;
            soft_ack_q <= 1'b0;
            // NOTE: div_q is a small flop array, not a RAM, so resetting every entry is legitimate.
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= '0;
            end
        end else begin
            soft_ack_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_rst_n_q[i]) begin
                    div_q[i]   <= div_d[i];
                    ch_ce_q[i] <= div_wrap[i];
                end else begin
                    div_q[i]   <= '0;
                    ch_ce_q[i] <= 1'b0;
                end
            end

            case (state_q)
                RUN: begin
                    // NOTE: later non-blocking assignments in the same block override the divider updates above.
                    if (go_soft) begin
                        state_q    <= SOFT;
                        cnt_q      <= '0;
                        ch_rst_n_q <= '0;
                        ch_ce_q    <= '0;
                        seq_done_q <= 1'b0;
                        soft_ack_q <= soft_req;
                        for (int i = 0; i < NUM_CH; i++) begin
                            div_q[i] <= '0;
                        end
                    end
                end
                default: begin
                    // SOFT counts as the first cycle of the replayed sequence, exactly like the reset cycle.
                    cnt_q      <= cnt_d;
                    ch_rst_n_q <= ch_rst_n_d;
                    if (last_rel) begin
                        state_q    <= RUN;
                        seq_done_q <= 1'b1;
                    end else begin
                        state_q <= HOLD;
                    end
                end
            endcase
        end
    end

    assign ch_rst_n = ch_rst_n_q;
    assign ch_ce    = ch_ce_q;
    assign seq_done = seq_done_q;
    assign soft_ack = soft_ack_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Self-checking bench for rst_seq_gen: directed release/soft/reset scenarios plus random traffic
// compared every cycle against an edge-count model of the release schedule.
module tb_rst_seq_gen;

    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 8;
    localparam int RST_LEN0 = 2;
    localparam int RST_STEP = 8;
    localparam int CE_DIV0  = 2;
    localparam int WDOG_LEN = 16;
    localparam int L_LAST   = RST_LEN0 + (NUM_CH - 1) * RST_STEP;

    logic              clk = 1'b0;
    logic              rst;
    logic              soft_req;
    logic              soft_ack;
    logic [NUM_CH-1:0] ch_rst_n;
    logic [NUM_CH-1:0] ch_ce;
    logic              seq_done;
`ifdef RST_SEQ_WDOG_EN
    logic              wdog_kick;
    logic              wdog_fired;
    int                m_wd;
    bit                m_fired;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;   // rising edges since the last reset edge or soft-reset edge
    bit m_ack    = 1'b0;

    rst_seq_gen #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .RST_LEN0(RST_LEN0),
        .RST_STEP(RST_STEP),
        .CE_DIV0 (CE_DIV0),
        .WDOG_LEN(WDOG_LEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .soft_req(soft_req),
        .soft_ack(soft_ack),
        .ch_rst_n(ch_rst_n),
        .ch_ce   (ch_ce),
        .seq_done(seq_done)
`ifdef RST_SEQ_WDOG_EN
        ,
        .wdog_kick (wdog_kick),
        .wdog_fired(wdog_fired)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected end before 1000000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rel_at(int i);
        return RST_LEN0 + i * RST_STEP;
    endfunction

    function automatic int per_at(int i);
        return CE_DIV0 << i;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_rst_n(int kk);
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = (kk >= rel_at(i));
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_ce(int kk);
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++)
            r[i] = (kk >= rel_at(i) + per_at(i)) && ((kk - rel_at(i)) % per_at(i) == 0);
        return r;
    endfunction

    // Advance the model by one rising edge using the inputs the DUT sampled on it.
    task automatic model_edge();
        bit running;
        bit fire;
        running = (k >= L_LAST);
        fire    = 1'b0;
        if (rst) begin
            k     = 0;
            m_ack = 1'b0;
`ifdef RST_SEQ_WDOG_EN
            m_wd    = 0;
            m_fired = 1'b0;
`endif
        end else begin
`ifdef RST_SEQ_WDOG_EN
            fire = running && (m_wd == WDOG_LEN - 1) && !wdog_kick;
            m_fired = fire;
            m_wd = (running && !fire && !soft_req && !wdog_kick) ? m_wd + 1 : 0;
`endif
            if (running && (soft_req || fire)) begin
                k     = 0;
                m_ack = soft_req;
            end else begin
                k++;
                m_ack = 1'b0;
            end
        end
    endtask

    task automatic compare();
        check("ch_rst_n", 32'(ch_rst_n), 32'(exp_rst_n(k)));
        check("ch_ce", 32'(ch_ce), 32'(exp_ce(k)));
        check("seq_done", 32'(seq_done), 32'(k >= L_LAST));
        check("soft_ack", 32'(soft_ack), 32'(m_ack));
`ifdef RST_SEQ_WDOG_EN
        check("wdog_fired", 32'(wdog_fired), 32'(m_fired));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        soft_req = 1'b0;
`ifdef RST_SEQ_WDOG_EN
        wdog_kick = 1'b1;
`endif
        repeat (5) step();
        rst = 1'b0;
    endtask

    int exp_rise [NUM_CH] = '{2, 10, 18, 26};
    int exp_ce1  [NUM_CH] = '{4, 14, 26, 42};
    int rise_at  [NUM_CH];
    int ce_first [NUM_CH];
    int ce_second[NUM_CH];
    int done_at;
    int ack_at;
    int rst_hold;
    int fires;
    int fire_at;
    logic ack_at_fire;

    initial begin
        rst      = 1'b1;
        soft_req = 1'b0;
`ifdef RST_SEQ_WDOG_EN
        wdog_kick = 1'b1;
        m_wd      = 0;
        m_fired   = 1'b0;
`endif

        // Release schedule and clock-enable phases from a clean reset.
        apply_reset();
        check("reset_rst_n", 32'(ch_rst_n), 32'h0);
        check("reset_done", 32'(seq_done), 32'h0);
        for (int i = 0; i < NUM_CH; i++) begin
            rise_at[i] = -1; ce_first[i] = -1; ce_second[i] = -1;
        end
        done_at = -1;
        for (int e = 1; e <= 64; e++) begin
            step();
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_rst_n[i] && rise_at[i] < 0) rise_at[i] = e;
                if (ch_ce[i]) begin
                    if (ce_first[i] < 0) ce_first[i] = e;
                    else if (ce_second[i] < 0) ce_second[i] = e;
                end
            end
            if (seq_done && done_at < 0) done_at = e;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            check($sformatf("rise_edge_ch%0d", i), 32'(rise_at[i]), 32'(exp_rise[i]));
            check($sformatf("first_ce_ch%0d", i), 32'(ce_first[i]), 32'(exp_ce1[i]));
            check($sformatf("ce_period_ch%0d", i), 32'(ce_second[i] - ce_first[i]), 32'(CE_DIV0 << i));
        end
        check("seq_done_edge", 32'(done_at), 32'd26);

        // Soft request raised during HOLD is serviced on the first RUN cycle, then replays.
        apply_reset();
        ack_at  = -1;
        done_at = -1;
        for (int e = 1; e <= 70; e++) begin
            if (e == 5) soft_req = 1'b1;
            step();
            if (soft_ack && ack_at < 0) begin
                ack_at   = e;
                soft_req = 1'b0;
            end
            if (ack_at > 0 && e > ack_at && seq_done && done_at < 0) done_at = e;
        end
        check("soft_ack_edge", 32'(ack_at), 32'd27);
        check("soft_replay_len", 32'(done_at - ack_at), 32'd26);

        // Reset asserted mid-sequence at edge 12.
        apply_reset();
        repeat (11) step();
        check("mid_rst_before", 32'(ch_rst_n), 32'b0011);
        rst = 1'b1;
        step();
        check("mid_rst_rst_n", 32'(ch_rst_n), 32'h0);
        check("mid_rst_ce", 32'(ch_ce), 32'h0);
        rst = 1'b0;
        repeat (25) step();
        check("mid_rst_not_done", 32'(seq_done), 32'h0);
        step();
        check("mid_rst_done", 32'(seq_done), 32'h1);

`ifdef RST_SEQ_WDOG_EN
        // Watchdog: no kicks fires after 16 RUN cycles; kicks every 10 cycles never fire.
        apply_reset();
        wdog_kick   = 1'b0;
        fire_at     = -1;
        ack_at_fire = 1'b1;
        for (int e = 1; e <= 100; e++) begin
            step();
            if (wdog_fired) begin
                fire_at     = e;
                ack_at_fire = soft_ack;
                break;
            end
        end
        check("wdog_fire_edge", 32'(fire_at), 32'(L_LAST + WDOG_LEN));
        check("wdog_fire_no_ack", 32'(ack_at_fire), 32'h0);
        fires = 0;
        for (int c = 0; c < 300; c++) begin
            wdog_kick = (c % 10 == 0);
            step();
            if (wdog_fired) fires++;
        end
        check("wdog_kicked_fires", 32'(fires), 32'h0);
        wdog_kick = 1'b0;
`endif

        // Random traffic: sporadic resets, well-behaved soft requesters, random kicks.
        apply_reset();
        rst_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rst_hold > 0) begin
                rst = 1'b1;
                rst_hold--;
            end else if ($urandom_range(0, 199) == 0) begin
                rst      = 1'b1;
                rst_hold = $urandom_range(0, 2);
            end else begin
                rst = 1'b0;
            end
            if (soft_req && soft_ack) soft_req = ($urandom_range(0, 9) == 0);
            else if (!soft_req) soft_req = ($urandom_range(0, 29) == 0);
`ifdef RST_SEQ_WDOG_EN
            wdog_kick = ($urandom_range(0, 11) == 0);
`endif
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
